// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// -----------------------------------------------------------------------------
// Shares one single-port synchronous RAM between instruction fetch (read-only)
// and the memory_op data stage (read/write). One RAM operation is issued per
// cycle. Data has fixed priority over fetch. A starvation counter forces fetch
// to win one cycle after STARVE_MAX consecutive denials. Read data returns one
// cycle after the read strobe and is steered to whichever requester issued the
// read.
//
// Parameters
//   STARVE_MAX : consecutive fetch denials tolerated before fetch is forced (1..15)
//   AW, DW     : address / data width
//
// Ports
//   clk, rst                     : clock (rising edge), async active-low reset
//   f_req, f_addr                : fetch read request
//   f_gnt                        : fetch granted this cycle (no grant = stall)
//   f_rvalid, f_rdata            : fetch read data return
//   d_req, d_we, d_addr, d_wdata : data request (read or write)
//   d_gnt                        : data granted/accepted this cycle
//   d_rvalid, d_rdata            : data read data return
//   ram_addr, ram_w_line         : RAM address / write data
//   ram_read, ram_write          : RAM strobes (mutually exclusive)
//   ram_r_line                   : RAM read data, valid the cycle after ram_read
//
// Build option
//   RAM_ARB_WRITE_BUFFER_EN : adds a one-entry posted write buffer so data
//                             writes can be accepted while fetch owns the RAM.
// -----------------------------------------------------------------------------
module ram_port_arbiter #(
    parameter int STARVE_MAX = 4,
    parameter int AW         = 32,
    parameter int DW         = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_gnt,
    output logic          f_rvalid,
    output logic [DW-1:0] f_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_w_line,
    output logic          ram_read,
    output logic          ram_write,
    input  logic [DW-1:0] ram_r_line
);

    // Which source owns the RAM port this cycle.
    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_F,
        SEL_D,
        SEL_WB
    } sel_t;

    // Which requester the read issued last cycle belongs to.
    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_F,
        OWN_D
    } own_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    sel_t          sel;
    own_t          owner_q;
    own_t          owner_next;
    logic [3:0]    starve_cnt;
    logic          starve_hit;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] f_rdata_q;
    logic [DW-1:0] d_rdata_q;

    assign starve_hit = f_req && (starve_cnt == STARVE_LIM);

`ifdef RAM_ARB_WRITE_BUFFER_EN
    logic          wb_valid;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          d_rd;
    logic          rd_hazard;
    logic          wr_accept;

    assign d_rd      = d_req && !d_we;
    // A read of the buffered address must wait for the drain so it sees the new data.
    assign rd_hazard = d_rd && wb_valid && (d_addr == wb_addr);
`endif

    // ------------------------------------------------------------------
    // Arbitration: pick the RAM owner for this cycle.
    // ------------------------------------------------------------------
    always_comb begin
        sel = SEL_NONE;
`ifdef RAM_ARB_WRITE_BUFFER_EN
        wr_accept = 1'b0;
        if (rst) begin
            if (starve_hit)
                sel = SEL_F;
            else if (d_rd && !rd_hazard)
                sel = SEL_D;
            else if (wb_valid)
                sel = SEL_WB;
            else if (f_req)
                sel = SEL_F;
            // Buffer acceptance is independent of who owns the RAM port; a
            // full buffer refuses and drains instead, accepting next cycle.
            wr_accept = d_req && d_we && !wb_valid;
        end
`else
        if (rst) begin
            if (starve_hit)
                sel = SEL_F;
            else if (d_req)
                sel = SEL_D;
            else if (f_req)
                sel = SEL_F;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Grants, RAM strobes and muxes, next read owner.
    // ------------------------------------------------------------------
    always_comb begin
        f_gnt      = (sel == SEL_F);
`ifdef RAM_ARB_WRITE_BUFFER_EN
        d_gnt      = (sel == SEL_D) || wr_accept;
        ram_w_line = (sel == SEL_WB) ? wb_data : d_wdata;
`else
        d_gnt      = (sel == SEL_D);
        ram_w_line = d_wdata;
`endif
        ram_read   = (sel == SEL_F) || ((sel == SEL_D) && !d_we);
        ram_write  = ((sel == SEL_D) && d_we) || (sel == SEL_WB);

        case (sel)
            SEL_F:   ram_addr = f_addr;
            SEL_D:   ram_addr = d_addr;
`ifdef RAM_ARB_WRITE_BUFFER_EN
            SEL_WB:  ram_addr = wb_addr;
`endif
            default: ram_addr = addr_q;
        endcase

        owner_next = OWN_NONE;
        if (sel == SEL_F)
            owner_next = OWN_F;
        else if ((sel == SEL_D) && !d_we)
            owner_next = OWN_D;
    end

    // Read data is forwarded straight from the RAM in the return cycle and
    // held from a register afterwards until the next return.
    assign f_rvalid = (owner_q == OWN_F);
    assign d_rvalid = (owner_q == OWN_D);
    assign f_rdata  = f_rvalid ? ram_r_line : f_rdata_q;
    assign d_rdata  = d_rvalid ? ram_r_line : d_rdata_q;

    // ------------------------------------------------------------------
    // State registers.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q    <= OWN_NONE;
            starve_cnt <= '0;
            addr_q     <= '0;
            f_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            owner_q <= owner_next;
            addr_q  <= ram_addr;

            if (f_req && !f_gnt) begin
                if (starve_cnt != STARVE_LIM)
                    starve_cnt <= starve_cnt + 4'd1;
            end else begin
                starve_cnt <= '0;
            end

            if (owner_q == OWN_F)
                f_rdata_q <= ram_r_line;
            if (owner_q == OWN_D)
                d_rdata_q <= ram_r_line;
        end
    end

`ifdef RAM_ARB_WRITE_BUFFER_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
        end else begin
            if (sel == SEL_WB)
                wb_valid <= 1'b0;
            if (wr_accept) begin
                wb_valid <= 1'b1;
                wb_addr  <= d_addr;
                wb_data  <= d_wdata;
            end
        end
    end
`endif

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single-port RAM interface (ram_*) between two requesters: instruction fetch and the memory_op data stage.
- Arbitrates one RAM operation per cycle and routes synchronous read data back to the requester that issued the read.
- Drives per-requester grants; a requester without a grant must hold its request, which the pipeline uses as a stall.
- Data has fixed priority, with a starvation counter guaranteeing fetch progress.

Parameters:
- STARVE_MAX, 4, consecutive cycles fetch may be denied before it is forced to win one cycle (1..15).
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-low
- f_req  in  1  fetch read request
- f_addr  in  AW  fetch address
- f_gnt  out  1  fetch granted this cycle
- f_rvalid  out  1  f_rdata valid
- f_rdata  out  DW  fetch read data
- d_req  in  1  data request
- d_we  in  1  data is write (1) or read (0)
- d_addr  in  AW  data address
- d_wdata  in  DW  data write value
- d_gnt  out  1  data granted/accepted this cycle
- d_rvalid  out  1  d_rdata valid
- d_rdata  out  DW  data read data
- ram_addr  out  AW  RAM address (shared read/write)
- ram_w_line  out  DW  RAM write data
- ram_read  out  1  RAM read strobe
- ram_write  out  1  RAM write strobe
- ram_r_line  in  DW  RAM read data, valid the cycle after ram_read

Behaviour:
- Reset (rst=0, async): f_gnt, d_gnt, f_rvalid, d_rvalid, ram_read, ram_write = 0; starve counter = 0; read-owner = NONE; rdata outputs = 0.
- Grant is combinational in cycle N from the current requests; ram_addr, ram_read, ram_write and ram_w_line are combinationally muxed from the winner in the same cycle N.
- At most one grant per cycle; ram_read and ram_write are never both 1.
- Priority: d_req beats f_req, except when the starve counter equals STARVE_MAX. In that case fetch wins and the counter clears.
- Starve counter:
  - increments (saturating at STARVE_MAX) each cycle f_req=1 and f_gnt=0;
  - clears when f_gnt=1 or f_req=0.
- Read latency is 1 cycle. A read granted in cycle N registers read-owner. In N+1 exactly one of f_rvalid/d_rvalid=1 for one cycle, and the matching rdata = ram_r_line (registered at the end of N+1, held until the next rvalid).
- Back-to-back reads, including alternating owners, sustain one per cycle; owner tracking is per cycle.
- Writes produce no rvalid. A granted write commits in cycle N (ram_write=1).
- No request: ram_* strobes = 0; ram_addr holds its last value.
- Requester contract: req, addr, we and wdata stay stable until gnt. The arbiter does not check this.
- Reset asserted mid-read: the pending rvalid is dropped and never emitted after reset release.

Optional Feature:
- Macro: RAM_ARB_WRITE_BUFFER_EN.
- Enabled: one-entry posted write buffer (addr, data, valid).
  - A data write is accepted (d_gnt=1) into an empty buffer in the same cycle even if fetch wins the RAM; the buffer-accept path does not count as a fetch denial.
  - The buffer drains (ram_write=1) in the first cycle with no granted data read. It drains ahead of fetch unless the starve counter = STARVE_MAX.
  - Buffer full plus a new data write: the buffer drains that cycle, d_gnt=0, and the new write is accepted next cycle.
  - A data read whose d_addr matches the buffered address gets d_gnt=0 until drained. Reads to other addresses bypass.
  - Reset clears buffer valid.
- Disabled: writes arbitrate exactly like reads, with no buffering and no address compare.

Test Plan:
- Reset then f_req=1, f_addr=0x100, ram_r_line=0xDEADBEEF next cycle -> f_gnt=1 in cycle 0, ram_read=1, ram_addr=0x100; f_rvalid=1, f_rdata=0xDEADBEEF in cycle 1; d_rvalid=0.
- f_req and d_req (read 0x200) both held in the same cycle -> d_gnt=1, f_gnt=0, ram_addr=0x200; the following cycle (d_req dropped) f_gnt=1.
- f_req held, d_req held continuously with STARVE_MAX=4 -> d_gnt cycles 0-3, f_gnt cycle 4, d_gnt cycles 5-8, f_gnt cycle 9.
- Alternating d read 0x10 / f read 0x20 on consecutive cycles with ram_r_line 0xA,0xB -> d_rvalid with 0xA then f_rvalid with 0xB; never both rvalids set.
- rst pulled low in the cycle after a read grant -> all outputs 0 asynchronously; after release no rvalid appears.
- With RAM_ARB_WRITE_BUFFER_EN: d write 0x40=0x55 while fetch wins -> d_gnt=1, f_gnt=1, ram_read=1. Next cycle a d read of 0x40 -> d_gnt=0, ram_write=1, addr 0x40, data 0x55. The cycle after that the read is granted.
